// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and defaults for the serdes transmit/receive pair
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

    localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - word-to-bit serializer with a one-word holding register
module parallel_to_serial
    import serdes_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] parallel_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              bit_en_i,
    output logic              serial_o,
    output logic              valid_o,
    output logic              last_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W);

    p2s_state_t        state, state_n;
    logic [DATA_W-1:0] shifter, shifter_n;
    logic [DATA_W-1:0] hold, hold_n;
    logic              hold_valid, hold_valid_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              serial_n, valid_n, last_n, busy_n;

    logic accept;
    logic emit;
    logic final_bit;
    logic head;

    assign ready_o   = !hold_valid;
    assign accept    = valid_i && ready_o;
    assign emit      = (state == SHIFT) && bit_en_i;
    assign final_bit = emit && (count == CNT_W'(DATA_W - 1));
    assign head      = LSB_FIRST ? shifter[0] : shifter[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shifter    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            count      <= '0;
            serial_o   <= 1'b0;
            valid_o    <= 1'b0;
            last_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            shifter    <= shifter_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
            count      <= count_n;
            serial_o   <= serial_n;
            valid_o    <= valid_n;
            last_o     <= last_n;
            busy_o     <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        shifter_n    = shifter;
        hold_n       = hold;
        hold_valid_n = hold_valid;
        count_n      = count;
        serial_n     = serial_o;
        valid_n      = 1'b0;
        last_n       = 1'b0;

        if (emit) begin
            serial_n  = head;
            valid_n   = 1'b1;
            last_n    = final_bit;
            shifter_n = LSB_FIRST ? (shifter >> 1) : (shifter << 1);
            count_n   = count + CNT_W'(1);
        end

        // A held word refills the shifter on the final bit so the next word follows without a bubble.
        if (final_bit) begin
            if (hold_valid) begin
                shifter_n    = hold;
                count_n      = '0;
                hold_valid_n = 1'b0;
            end else begin
                state_n = IDLE;
            end
        end

        // accept implies hold is empty, so it never collides with the hold transfer above
        if (accept) begin
            if ((state == IDLE) || final_bit) begin
                shifter_n = parallel_i;
                count_n   = '0;
                state_n   = SHIFT;
            end else begin
                hold_n       = parallel_i;
                hold_valid_n = 1'b1;
            end
        end

        busy_n = (state_n == SHIFT) || hold_valid_n;
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - directed self-checking bench for parallel_to_serial
module tb_parallel_to_serial;
    import serdes_pkg::*;

    logic        clk;
    logic        rst_n;

    logic [7:0]  p8;
    logic        v8_i, r8, en8, s8, v8, l8, b8;
    logic [11:0] p12;
    logic        v12_i, r12, en12, s12, v12, l12, b12;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] d, lm;
    int          g, lead, lowc, nb, extra;
    logic        tog_done;

    parallel_to_serial #(.DATA_W(8), .LSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .parallel_i(p8), .valid_i(v8_i), .ready_o(r8),
        .bit_en_i(en8), .serial_o(s8), .valid_o(v8), .last_o(l8), .busy_o(b8)
    );

    parallel_to_serial #(.DATA_W(12), .LSB_FIRST(1'b0)) dut12 (
        .clk(clk), .rst_n(rst_n), .parallel_i(p12), .valid_i(v12_i), .ready_o(r12),
        .bit_en_i(en12), .serial_o(s12), .valid_o(v12), .last_o(l12), .busy_o(b12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [31:0] w);
        int c;
        if (sel) begin p12 = w[11:0]; v12_i = 1'b1; end
        else     begin p8  = w[7:0];  v8_i  = 1'b1; end
        c = 0;
        while (!(sel ? r12 : r8) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("send_ready", {31'b0, c < 200}, 1);
        @(negedge clk);
        if (sel) v12_i = 1'b0;
        else     v8_i  = 1'b0;
    endtask

    task automatic collect(input bit sel, input bit msb, input int nbits, input int budget,
                           output logic [31:0] data, output logic [31:0] lastm,
                           output int gaps, output int first);
        int   n;
        logic vv, ss, ll;
        n = 0; gaps = 0; first = 0; data = '0; lastm = '0;
        for (int c = 1; c <= budget && n < nbits; c++) begin
            @(negedge clk);
            vv = sel ? v12 : v8;
            ss = sel ? s12 : s8;
            ll = sel ? l12 : l8;
            if (vv) begin
                if (n == 0) first = c;
                if (msb) data = {data[30:0], ss};
                else     data[n] = ss;
                lastm[n] = ll;
                n++;
            end else if (n > 0) begin
                gaps++;
            end
        end
        check("collect_bit_count", n, nbits);
    endtask

    // A hold->shifter transfer and a new accept must never share an edge.
    always @(negedge clk) begin
        #4;
        if (rst_n && dut8.state == SHIFT && en8 && dut8.count == 3'd7 && dut8.hold_valid)
            check("xfer_no_accept", {31'b0, v8_i & r8}, 0);
    end

    initial begin
        rst_n = 1'b0;
        p8 = '0; v8_i = 1'b0; en8 = 1'b1;
        p12 = '0; v12_i = 1'b0; en12 = 1'b1;
        tog_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", r8, 1);
        check("rst_valid", v8, 0);
        check("rst_serial", s8, 0);
        check("rst_last", l8, 0);
        check("rst_busy", b8, 0);
        check("rst_ready12", r12, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // single word A5, LSB first
        send(0, 32'hA5);
        check("t1_no_bit_yet", v8, 0);
        check("t1_busy", b8, 1);
        collect(0, 0, 8, 40, d, lm, g, lead);
        check("t1_data", d, 32'hA5);
        check("t1_last", lm, 32'h80);
        check("t1_gaps", g, 0);
        check("t1_latency", lead, 1);
        check("t1_busy_clear", b8, 0);
        @(negedge clk);
        check("t1_valid_end", v8, 0);

        // back-to-back 3C then C3
        fork
            begin
                send(0, 32'h3C);
                send(0, 32'hC3);
                check("t2_ready_low", r8, 0);
                lowc = 0;
                while (!r8 && lowc < 50) begin
                    @(negedge clk);
                    lowc++;
                end
                check("t2_ready_low_cycles", lowc, 7);
            end
            collect(0, 0, 16, 80, d, lm, g, lead);
        join
        check("t2_data", d, 32'hC33C);
        check("t2_last", lm, 32'h8080);
        check("t2_gaps", g, 0);

        // backpressure: third word waits for ready
        fork
            begin
                send(0, 32'h01);
                send(0, 32'h80);
                send(0, 32'hFF);
            end
            collect(0, 0, 24, 100, d, lm, g, lead);
        join
        check("t3_data", d, 32'hFF8001);
        check("t3_last", lm, 32'h808080);
        check("t3_gaps", g, 0);
        @(negedge clk);
        check("t3_no_extra", v8, 0);

        // bit_en_i alternating on 96
        tog_done = 1'b0;
        fork
            send(0, 32'h96);
            begin
                collect(0, 0, 8, 60, d, lm, g, lead);
                tog_done = 1'b1;
            end
            begin
                for (int i = 0; i < 100 && !tog_done; i++) begin
                    @(negedge clk);
                    en8 = ~en8;
                end
                en8 = 1'b1;
            end
        join
        check("t4_data", d, 32'h96);
        check("t4_last", lm, 32'h80);
        check("t4_gaps", g, 7);
        repeat (3) @(negedge clk);

        // reset mid-word with a held word
        send(0, 32'hF0);
        send(0, 32'h0F);
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            if (v8) nb++;
            if (nb == 3) break;
            @(negedge clk);
        end
        check("t5_three_bits", nb, 3);
        check("t5_held", r8, 0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", v8, 0);
        check("t5_rst_serial", s8, 0);
        check("t5_rst_last", l8, 0);
        check("t5_rst_busy", b8, 0);
        check("t5_rst_ready", r8, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 32'h55);
        collect(0, 0, 8, 40, d, lm, g, lead);
        check("t5_data", d, 32'h55);
        check("t5_last", lm, 32'h80);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (v8) extra++;
        end
        check("t5_hold_discarded", extra, 0);
        check("t5_idle_busy", b8, 0);

        // MSB first, 12-bit A5C -> 1,0,1,0,0,1,0,1,1,1,0,0
        send(1, 32'hA5C);
        collect(1, 1, 12, 60, d, lm, g, lead);
        check("t6_data", d, 32'hA5C);
        check("t6_last", lm, 32'h800);
        check("t6_gaps", g, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
